// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types for the UART receive frame controller.
// Holds FSM state, parity mode decode and the minimum data width.
package uart_rx_pkg;

    localparam int MIN_DATA_BITS = 5;

    typedef enum logic [2:0] {
        IDLE,
        RTS_WAIT,
        SCAN,
        START,
        DATA,
        PARITY,
        STOP,
        FINISH
    } rx_state_t;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        EVEN  = 3'd1,
        ODD   = 3'd2,
        MARK  = 3'd3,
        SPACE = 3'd4
    } parity_mode_t;

    function automatic parity_mode_t decode_parity(input logic [2:0] m);
        return (m > 3'd4) ? NONE : parity_mode_t'(m);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// uart_rx_bit_sampler: oversample counter and mid-bit sample strobe.
// Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling.
module uart_rx_bit_sampler #(
    parameter int OVS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic baud_tick_i,
    input  logic rx_i,
    output logic sample_strobe_o,
    output logic sample_bit_o
);
    import uart_rx_pkg::*;

    localparam int CNT_W = $clog2(OVS);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = (cnt == CNT_W'(OVS - 1)) ? '0 : cnt + CNT_W'(1);

    // Tick counter wraps every bit period; clear aligns it to the start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (baud_tick_i) begin
            cnt <= cnt_nxt;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    if (OVS < 8) begin : g_ovs_chk
        $error("majority vote needs OVS >= 8");
    end

    logic s0;
    logic s1;

    // Capture the two samples ahead of the decision tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (clear_i) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
        end else if (baud_tick_i) begin
            if (cnt_nxt == CNT_W'(OVS / 2 - 2)) s0 <= rx_i;
            if (cnt_nxt == CNT_W'(OVS / 2 - 1)) s1 <= rx_i;
        end
    end

    assign sample_strobe_o = baud_tick_i & ~clear_i
                           & (cnt_nxt == CNT_W'(OVS / 2));
    assign sample_bit_o    = (s0 & s1) | (s0 & rx_i) | (s1 & rx_i);
`else
    assign sample_strobe_o = baud_tick_i & ~clear_i
                           & (cnt_nxt == CNT_W'(OVS / 2 - 1));
    assign sample_bit_o    = rx_i;
`endif

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame FSM, shift register and errors.
// Optional majority sampling via UART_RX_MAJORITY_VOTE_EN.
module uart_rx_frame_ctrl #(
    parameter int DATA_W_MAX = 9,
    parameter int OVS        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_en_i,
    input  logic                  rts_ni,
    input  logic                  rx_i,
    input  logic                  baud_tick_i,
    input  logic [3:0]            data_bits_i,
    input  logic [2:0]            parity_mode_i,
    input  logic                  stop2_i,
    output logic [DATA_W_MAX-1:0] data_o,
    output logic                  data_o_valid,
    output logic                  parity_err_o,
    output logic                  frame_err_o,
    output logic                  break_o,
    output logic                  receive_en,
    output logic                  busy_o
);
    import uart_rx_pkg::*;

    if (DATA_W_MAX < MIN_DATA_BITS || DATA_W_MAX > 15) begin : g_w_chk
        $error("DATA_W_MAX out of range");
    end
    if (OVS < 4 || (OVS % 2) != 0) begin : g_ovs_chk
        $error("OVS must be even and >= 4");
    end

    function automatic logic [3:0] clamp_bits(input logic [3:0] b);
        if (b < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
        else if (b > 4'(DATA_W_MAX)) return 4'(DATA_W_MAX);
        else return b;
    endfunction

    rx_state_t                state;
    rx_state_t                nxt;
    parity_mode_t             pmode;
    logic [3:0]               n_bits;
    logic                     stop2;
    logic [3:0]               bit_cnt;
    logic                     stop_cnt;
    logic [DATA_W_MAX-1:0]    shreg;
    logic [3:0]               shamt;
    logic                     rx_prev;
    logic                     fall;
    logic                     start_go;
    logic                     strobe;
    logic                     sbit;
    logic                     par_acc;
    logic                     zero_acc;
    logic                     perr_acc;
    logic                     ferr_acc;
    logic                     exp_par;

    assign fall     = rx_prev & ~rx_i;
    assign start_go = (nxt == START) && (state != START);
    assign shamt    = 4'(DATA_W_MAX) - n_bits;

    uart_rx_bit_sampler #(
        .OVS (OVS)
    ) u_sampler (
        .clk             (clk),
        .reset           (reset),
        .clear_i         (start_go),
        .baud_tick_i     (baud_tick_i),
        .rx_i            (rx_i),
        .sample_strobe_o (strobe),
        .sample_bit_o    (sbit)
    );

    // Expected parity bit for the latched mode.
    always_comb begin
        exp_par = 1'b0;
        unique case (pmode)
            EVEN:    exp_par = par_acc;
            ODD:     exp_par = ~par_acc;
            MARK:    exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    // Next-state decode for the frame FSM.
    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (rx_en_i) nxt = RTS_WAIT;
            RTS_WAIT: if (!rx_en_i) nxt = IDLE;
                      else if (!rts_ni) nxt = SCAN;
            SCAN:     if (!rx_en_i) nxt = IDLE;
                      else if (fall) nxt = START;
            START:    if (strobe) nxt = sbit ? SCAN : DATA;
            DATA:     if (strobe && bit_cnt == n_bits - 4'd1)
                          nxt = (pmode == NONE) ? STOP : PARITY;
            PARITY:   if (strobe) nxt = STOP;
            STOP:     if (strobe && stop_cnt == stop2) nxt = FINISH;
            FINISH:   if (rx_en_i && !rts_ni) nxt = fall ? START : SCAN;
                      else if (rx_en_i) nxt = RTS_WAIT;
                      else nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end

    // State, datapath accumulation and registered frame report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            rx_prev      <= 1'b1;
            pmode        <= NONE;
            n_bits       <= '0;
            stop2        <= 1'b0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            shreg        <= '0;
            par_acc      <= 1'b0;
            zero_acc     <= 1'b0;
            perr_acc     <= 1'b0;
            ferr_acc     <= 1'b0;
            data_o       <= '0;
            data_o_valid <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            receive_en   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state        <= nxt;
            rx_prev      <= rx_i;
            busy_o       <= !(nxt inside {IDLE, RTS_WAIT, SCAN});
            receive_en   <= nxt inside {START, DATA, PARITY, STOP};
            data_o_valid <= 1'b0;
            if (start_go) begin
                n_bits   <= clamp_bits(data_bits_i);
                pmode    <= decode_parity(parity_mode_i);
                stop2    <= stop2_i;
                bit_cnt  <= '0;
                stop_cnt <= 1'b0;
                shreg    <= '0;
                par_acc  <= 1'b0;
                zero_acc <= 1'b1;
                perr_acc <= 1'b0;
                ferr_acc <= 1'b0;
            end else if (strobe) begin
                unique case (state)
                    DATA: begin
                        shreg    <= {sbit, shreg[DATA_W_MAX-1:1]};
                        par_acc  <= par_acc ^ sbit;
                        zero_acc <= zero_acc & ~sbit;
                        bit_cnt  <= (nxt == DATA) ? bit_cnt + 4'd1 : '0;
                    end
                    PARITY: begin
                        perr_acc <= sbit ^ exp_par;
                        zero_acc <= zero_acc & ~sbit;
                    end
                    STOP: begin
                        stop_cnt <= 1'b1;
                        ferr_acc <= ferr_acc | ~sbit;
                        zero_acc <= zero_acc & ~sbit;
                        if (nxt == FINISH) begin
                            data_o       <= shreg >> shamt;
                            parity_err_o <= perr_acc;
                            frame_err_o  <= ferr_acc | ~sbit;
                            break_o      <= zero_acc & ~sbit;
                            data_o_valid <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: scoreboard bench for uart_rx_frame_ctrl.
// Directed plan frames plus randomized frames against a frame-level model.
module tb_uart_rx_frame_ctrl;

    localparam int OVS  = 16;
    localparam int DW   = 9;
    localparam int TDIV = 3;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int MV = 1;
`else
    localparam int MV = 0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        bit            perr;
        bit            ferr;
        bit            brk;
        int            cyc;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          rx_en_i;
    logic          rts_ni;
    logic          rx_i;
    logic          baud_tick_i;
    logic [3:0]    data_bits_i;
    logic [2:0]    parity_mode_i;
    logic          stop2_i;
    logic [DW-1:0] data_o;
    logic          data_o_valid;
    logic          parity_err_o;
    logic          frame_err_o;
    logic          break_o;
    logic          receive_en;
    logic          busy_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   tdiv   = 0;
    exp_t exp_q[$];

    uart_rx_frame_ctrl #(
        .DATA_W_MAX (DW),
        .OVS        (OVS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_en_i       (rx_en_i),
        .rts_ni        (rts_ni),
        .rx_i          (rx_i),
        .baud_tick_i   (baud_tick_i),
        .data_bits_i   (data_bits_i),
        .parity_mode_i (parity_mode_i),
        .stop2_i       (stop2_i),
        .data_o        (data_o),
        .data_o_valid  (data_o_valid),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .break_o       (break_o),
        .receive_en    (receive_en),
        .busy_o        (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        baud_tick_i = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick_i = (tdiv == 0);
            tdiv = (tdiv + 1) % TDIV;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cyc %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit rule_parity(input logic [DW-1:0] w, input int pm);
        int ones;
        ones = $countones(w);
        case (pm)
            1:       return (ones % 2) == 1;
            2:       return (ones % 2) == 0;
            3:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t model(input logic [DW-1:0] w, input bit has_par,
                                   input int pm, input bit pbit, input bit s2,
                                   input bit st0, input bit st1);
        exp_t m;
        m.data = w;
        m.perr = has_par && (pbit != rule_parity(w, pm));
        m.ferr = !st0 || (s2 && !st1);
        m.brk  = (w == 0) && (!has_par || !pbit) && !st0 && (!s2 || !st1);
        m.cyc  = 0;
        return m;
    endfunction

    task automatic next_tick();
        do begin
            @(negedge clk);
            #1;
        end while (!baud_tick_i);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) next_tick();
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", exp_q.size(), 0);
    endtask

    task automatic send_frame(input logic [DW-1:0] word, input int nb,
                              input int pm, input bit s2, input bit par_bad,
                              input bit st0, input bit st1, input int idle,
                              input bit push, input int dis);
        int            n;
        bit            has_par;
        bit            pbit;
        exp_t          e;
        logic [DW-1:0] w;
        n       = (nb < 5) ? 5 : (nb > DW) ? DW : nb;
        has_par = (pm >= 1 && pm <= 4);
        w       = word & DW'((1 << n) - 1);
        pbit    = rule_parity(w, pm) ^ par_bad;
        data_bits_i   = 4'(nb);
        parity_mode_i = 3'(pm);
        stop2_i       = s2;
        e = model(w, has_par, pm, pbit, s2, st0, st1);
        e.cyc = cyc + (OVS / 2 - 1 + MV
                + OVS * (n + int'(has_par) + 1 + int'(s2))) * TDIV + 1;
        if (push) exp_q.push_back(e);
        rx_i = 1'b0;
        wait_ticks(OVS);
        data_bits_i   = 4'($urandom_range(0, 15));
        parity_mode_i = 3'($urandom_range(0, 7));
        stop2_i       = 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            rx_i = w[i];
            if (i == 1) begin
                if (dis[0]) rx_en_i = 1'b0;
                if (dis[1]) rts_ni = 1'b1;
            end
            wait_ticks(OVS);
        end
        if (has_par) begin
            rx_i = pbit;
            wait_ticks(OVS);
        end
        rx_i = st0;
        wait_ticks(OVS);
        if (s2) begin
            rx_i = st1;
            wait_ticks(OVS);
        end
        rx_en_i = 1'b1;
        rts_ni  = 1'b0;
        rx_i    = 1'b1;
        if (dis != 0 && idle < 2) idle = 2;
        if (!(s2 ? st1 : st0) && idle < 1) idle = 1;
        wait_ticks(idle);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_o_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(data_o_valid), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", 32'(data_o), 32'(e.data));
                    chk("parity_err", 32'(parity_err_o), 32'(e.perr));
                    chk("frame_err", 32'(frame_err_o), 32'(e.ferr));
                    chk("break", 32'(break_o), 32'(e.brk));
                    chk("valid_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        int   dis;
        reset         = 1'b1;
        rx_en_i       = 1'b0;
        rts_ni        = 1'b1;
        rx_i          = 1'b1;
        data_bits_i   = 4'd8;
        parity_mode_i = 3'd0;
        stop2_i       = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data", 32'(data_o), 0);
        chk("rst_valid", 32'(data_o_valid), 0);
        chk("rst_perr", 32'(parity_err_o), 0);
        chk("rst_ferr", 32'(frame_err_o), 0);
        chk("rst_brk", 32'(break_o), 0);
        chk("rst_rxen", 32'(receive_en), 0);
        chk("rst_busy", 32'(busy_o), 0);
        reset   = 1'b0;
        rx_en_i = 1'b1;
        rts_ni  = 1'b0;
        wait_ticks(4);

        send_frame(9'h0A5, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 0);
        chk("idle_busy", 32'(busy_o), 0);
        chk("idle_rxen", 32'(receive_en), 0);

        send_frame(9'h041, 7, 1, 1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 0);

        rx_i = 1'b0;
        wait_ticks(4);
        rx_i = 1'b1;
        wait_ticks(2 * OVS);
        send_frame(9'h03C, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 1'b1, 0);

        send_frame(9'h1FF, 9, 2, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1, 0);

        data_bits_i   = 4'd8;
        parity_mode_i = 3'd0;
        stop2_i       = 1'b0;
        e = model('0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        e.cyc = cyc + (OVS / 2 - 1 + MV + OVS * 9) * TDIV + 1;
        exp_q.push_back(e);
        rx_i = 1'b0;
        wait_ticks(20 * OVS);
        rx_i = 1'b1;
        wait_ticks(4);

        rx_en_i = 1'b0;
        rts_ni  = 1'b1;
        next_tick();
        rx_en_i = 1'b1;
        next_tick();
        send_frame(9'h0E7, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b0, 0);
        send_frame(9'h05A, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b1, 0);

        for (int k = 0; k < 40; k++) begin
            dis = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            send_frame(9'($urandom_range(0, 511)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0),
                       ($urandom_range(0, 7) != 0),
                       ($urandom_range(0, 7) != 0),
                       int'($urandom_range(0, 6)), 1'b1, dis);
        end
        drain();

        data_bits_i   = 4'd8;
        parity_mode_i = 3'd0;
        stop2_i       = 1'b0;
        rx_i = 1'b0;
        wait_ticks(OVS);
        rx_i = 1'b1;
        wait_ticks(OVS);
        rx_i = 1'b0;
        wait_ticks(OVS);
        rx_i = 1'b1;
        wait_ticks(OVS / 2);
        chk("mid_busy", 32'(busy_o), 1);
        chk("mid_rxen", 32'(receive_en), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_data", 32'(data_o), 0);
        chk("arst_valid", 32'(data_o_valid), 0);
        chk("arst_perr", 32'(parity_err_o), 0);
        chk("arst_ferr", 32'(frame_err_o), 0);
        chk("arst_brk", 32'(break_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_rxen", 32'(receive_en), 0);
        rx_i = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_ticks(3);
        send_frame(9'h096, 8, 0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 1'b1, 0);
        drain();
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
